// File: rtl/i8008_bus_responder_pkg.sv
// i8008_bus_responder_pkg: shared bus state/cycle encodings for the i8008 bus responder
package i8008_bus_responder_pkg;
    typedef enum logic [2:0] {
        WAIT    = 3'b000,
        T2      = 3'b001,
        T1      = 3'b010,
        T1I     = 3'b011,
        T3      = 3'b100,
        T5      = 3'b101,
        STOPPED = 3'b110,
        T4      = 3'b111
    } state_t;
    typedef enum logic [1:0] {
        PCI = 2'b00,
        PCC = 2'b01,
        PCR = 2'b10,
        PCW = 2'b11
    } cycle_t;
    localparam logic [4:0] OUT_PORT_MIN = 5'd8;
    function automatic logic is_mem_read(cycle_t c);
        return c == PCI || c == PCR;
    endfunction
endpackage

// File: rtl/i8008_byte_mem.sv
// i8008_byte_mem: byte memory with asynchronous read and synchronous write, no reset
module i8008_byte_mem #(
    parameter int DEPTH = 1024,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic [7:0]    wdata,
    output logic [7:0]    rdata
);
    logic [7:0] mem [DEPTH];
    always_ff @(posedge clk)
        if (we) mem[addr] <= wdata;
    assign rdata = mem[addr];
endmodule

// File: rtl/i8008_bus_responder.sv
// i8008_bus_responder: memory/I-O side of the i8008 bus; I8008_INTR_JAM_EN adds interrupt RST jamming
module i8008_bus_responder
    import i8008_bus_responder_pkg::*;
#(
    parameter int         MEM_DEPTH   = 1024,
    parameter int         WAIT_CYCLES = 0,
    parameter logic [2:0] RST_VEC     = 3'd0
) (
    input  logic       clk,
    input  logic       rst,
    input  state_t     state,
    input  logic       Sync,
    input  logic [7:0] D_out,
    output logic [7:0] D_in,
    output logic       READY,
    output logic       INTR,
    input  logic       irq_req,
    input  logic [7:0] io_in_data,
    output logic [7:0] io_out_data,
    output logic [4:0] io_out_port,
    output logic       io_out_valid
);
    localparam int AW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WAIT_LAST = 4'(WAIT_CYCLES - 1);
    localparam logic [7:0] JAM_OP = {2'b00, RST_VEC, 3'b101};
    logic [7:0]  addr_lo, acc_lat, mem_rdata;
    logic [5:0]  addr_hi;
    logic [13:0] addr;
    logic [4:0]  port;
    logic [3:0]  wait_cnt;
    cycle_t      cyc;
    logic        jam_pending, is_t1, is_out, we, unused_ok;
    assign addr   = {addr_hi, addr_lo};
    assign is_t1  = state == T1 || state == T1I;
    assign is_out = state == T3 && cyc == PCC && port >= OUT_PORT_MIN;
    // a reset asserted during T3 must abandon the write
    assign we     = state == T3 && cyc == PCW && !rst;
    assign unused_ok = ^{Sync, irq_req, addr};
    i8008_byte_mem #(.DEPTH(MEM_DEPTH)) u_mem (
        .clk  (clk),
        .we   (we),
        .addr (addr[AW-1:0]),
        .wdata(D_out),
        .rdata(mem_rdata)
    );
    assign READY = state == T2   ? WAIT_CYCLES == 0 :
                   state == WAIT ? wait_cnt == WAIT_LAST : 1'b1;
    assign D_in = state != T3                          ? 8'h00 :
                  is_mem_read(cyc)                     ? (jam_pending ? JAM_OP : mem_rdata) :
                  cyc == PCC && port < OUT_PORT_MIN    ? io_in_data : 8'h00;
    always_ff @(posedge clk) begin
        if (rst) begin
            addr_lo      <= '0;
            acc_lat      <= '0;
            addr_hi      <= '0;
            port         <= '0;
            wait_cnt     <= '0;
            cyc          <= PCI;
            io_out_data  <= '0;
            io_out_port  <= '0;
            io_out_valid <= 1'b0;
        end else begin
            if (is_t1) begin
                addr_lo  <= D_out;
                acc_lat  <= D_out;
                wait_cnt <= '0;
            end
            if (state == T2) begin
                addr_hi <= D_out[5:0];
                cyc     <= cycle_t'(D_out[7:6]);
                port    <= D_out[5:1];
            end
            if (state == WAIT) wait_cnt <= wait_cnt + 4'd1;
            io_out_valid <= is_out;
            if (is_out) begin
                io_out_data <= acc_lat;
                io_out_port <= port;
            end
        end
    end
`ifdef I8008_INTR_JAM_EN
    logic intr_q;
    always_ff @(posedge clk) begin
        if (rst) begin
            intr_q      <= 1'b0;
            jam_pending <= 1'b0;
        end else begin
            intr_q      <= state == T1I ? 1'b0 : irq_req ? 1'b1 : intr_q;
            jam_pending <= state == T1I ? 1'b1 : state == T3 ? 1'b0 : jam_pending;
        end
    end
    assign INTR = intr_q;
`else
    assign INTR        = 1'b0;
    assign jam_pending = 1'b0;
`endif
endmodule
